// File: rtl/accel_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler, the SPI burst-read engine
// and the byte UART transmitter.
`timescale 1ns/1ps
interface accel_frame_scheduler_if;
    logic        o_spi_start;
    logic        i_spi_done;
    logic [47:0] i_sample;
    logic        o_uart_enb;
    logic [7:0]  o_uart_data;
    logic        i_uart_ready;

    modport master (
        output o_spi_start, o_uart_enb, o_uart_data,
        input  i_spi_done, i_sample, i_uart_ready
    );

    modport slave (
        input  o_spi_start, o_uart_enb, o_uart_data,
        output i_spi_done, i_sample, i_uart_ready
    );
endinterface

// File: rtl/accel_frame_scheduler.sv
// Periodically triggers a 6-byte accelerometer read and streams the result
// as an 8-byte SYNC/X/Y/Z/CHK frame to the UART transmitter.
`timescale 1ns/1ps
module accel_frame_scheduler #(
    parameter int unsigned PERIOD_CYC  = 500000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_enb,
    accel_frame_scheduler_if.master        bus,
    output logic                           o_busy,
    output logic [7:0]                     o_drop_cnt,
    output logic                           o_spi_timeout
);
    localparam int PER_W = $clog2(PERIOD_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_SPI, SEND, ACK, DRAIN} state_t;

    state_t            state, state_nxt;
    logic              enb_q;
    logic [PER_W-1:0]  per_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [47:0]       sample_q;
    logic [7:0]        chk_q;
    logic [2:0]        idx;
    logic              uart_enb_q;
    logic [7:0]        uart_data_q;
    logic [7:0]        drop_cnt;
    logic              timeout_q;
    logic              tick;
    logic              spi_start, latch, load, idx_inc, to_hit;

    function automatic logic [7:0] checksum(input logic [47:0] s);
        checksum = s[47:40] ^ s[39:32] ^ s[31:24] ^ s[23:16] ^ s[15:8] ^ s[7:0];
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [47:0] s,
                                              input logic [7:0] c);
        case (i)
            3'd0:    frame_byte = SYNC_BYTE;
            3'd7:    frame_byte = c;
            default: frame_byte = 8'(s >> (8 * (6 - int'(i))));
        endcase
    endfunction

    // The enable is sampled once before counting so the first tick lands
    // PERIOD_CYC cycles after i_enb rises.
    assign tick = i_enb && enb_q && (per_cnt == PER_W'(PERIOD_CYC - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        spi_start = 1'b0;
        latch     = 1'b0;
        load      = 1'b0;
        idx_inc   = 1'b0;
        to_hit    = 1'b0;
        unique case (state)
            IDLE:     if (tick) state_nxt = START;
            START: begin
                spi_start = 1'b1;
                state_nxt = WAIT_SPI;
            end
            WAIT_SPI: begin
                if (bus.i_spi_done) begin
                    latch     = 1'b1;
                    state_nxt = SEND;
                end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    to_hit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SEND: begin
                if (bus.i_uart_ready) begin
                    load      = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:      if (!bus.i_uart_ready) state_nxt = DRAIN;
            DRAIN: begin
                if (bus.i_uart_ready) begin
                    if (idx == 3'd7) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = SEND;
                    end
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            enb_q       <= 1'b0;
            per_cnt     <= '0;
            to_cnt      <= '0;
            sample_q    <= '0;
            chk_q       <= '0;
            idx         <= '0;
            uart_enb_q  <= 1'b0;
            uart_data_q <= '0;
            drop_cnt    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            enb_q <= i_enb;
            if (!i_enb) begin
                per_cnt <= '0;
            end else if (enb_q) begin
                per_cnt <= tick ? '0 : per_cnt + PER_W'(1);
            end

            if (state == START) begin
                to_cnt <= '0;
            end else if (state == WAIT_SPI) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (latch) begin
                sample_q <= bus.i_sample;
                chk_q    <= checksum(bus.i_sample);
                idx      <= '0;
            end else if (idx_inc) begin
                idx <= idx + 3'd1;
            end

            // Data register holds the last byte until the next load.
            uart_enb_q <= load;
            if (load) begin
                uart_data_q <= frame_byte(idx, sample_q, chk_q);
            end

            if (to_hit) begin
                timeout_q <= 1'b1;
            end

            if (tick && (state != IDLE) && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign bus.o_spi_start = spi_start;
    assign bus.o_uart_enb  = uart_enb_q;
    assign bus.o_uart_data = uart_data_q;
    assign o_busy          = (state != IDLE);
    assign o_drop_cnt      = drop_cnt;
    assign o_spi_timeout   = timeout_q;
endmodule
